// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: folds E0/F0/E1 prefixes into key events,
// tracks shift/ctrl/alt and queues events in a first-word-fall-through FIFO.
module ps2_scancode_decoder #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       code_valid,
    input  logic [7:0] code_in,
    output logic       evt_valid,
    output logic [9:0] evt_data,
    input  logic       evt_pop,
    output logic       shift_held,
    output logic       ctrl_held,
    output logic       alt_held,
    output logic       overflow,
    input  logic       ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    skip_q, skip_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [5:0]    mod_q, mod_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic          ovf_q, ovf_d;
    logic [9:0]    mem_q [DEPTH];

    logic       is_ctrl, is_pfx, is_fake;
    logic       evt_made;
    logic [9:0] evt_new;
    logic       empty, full, do_pop, do_push, drop;

    assign is_ctrl = code_in inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFC};
    assign is_pfx  = code_in inside {8'hE0, 8'hF0, 8'hE1};
    assign is_fake = (code_in == 8'h12) || (code_in == 8'h59);

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        tmo_d    = tmo_q;
        evt_made = 1'b0;
        evt_new  = '0;

        // A stalled prefix is abandoned so a lost byte cannot corrupt the next key.
        if (state_q == IDLE || code_valid) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end

        if (code_valid) begin
            case (state_q)
                IDLE: begin
                    if (code_in == 8'hE0) begin
                        state_d = EXT;
                    end else if (code_in == 8'hF0) begin
                        state_d = BRK;
                    end else if (code_in == 8'hE1) begin
                        state_d = SKIP;
                        skip_d  = 3'd7;
                    end else if (!is_ctrl) begin
                        evt_made = 1'b1;
                        evt_new  = {2'b00, code_in};
                    end
                end
                EXT: begin
                    state_d = IDLE;
                    if (code_in == 8'hF0) begin
                        state_d = EXT_BRK;
                    end else if (!is_fake && !is_pfx && !is_ctrl) begin
                        evt_made = 1'b1;
                        evt_new  = {2'b01, code_in};
                    end
                end
                BRK: begin
                    state_d = IDLE;
                    if (!is_pfx && !is_ctrl) begin
                        evt_made = 1'b1;
                        evt_new  = {2'b10, code_in};
                    end
                end
                EXT_BRK: begin
                    state_d = IDLE;
                    if (!is_fake && !is_pfx && !is_ctrl) begin
                        evt_made = 1'b1;
                        evt_new  = {2'b11, code_in};
                    end
                end
                SKIP: begin
                    skip_d = skip_q - 3'd1;
                    if (skip_q == 3'd1) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        mod_d = mod_q;
        if (evt_made) begin
            case (evt_new[8:0])
                9'h012:  mod_d[0] = ~evt_new[9];
                9'h059:  mod_d[1] = ~evt_new[9];
                9'h014:  mod_d[2] = ~evt_new[9];
                9'h114:  mod_d[3] = ~evt_new[9];
                9'h011:  mod_d[4] = ~evt_new[9];
                9'h111:  mod_d[5] = ~evt_new[9];
                default: mod_d = mod_q;
            endcase
        end
    end

    // A pop frees the head slot this cycle, so a push into a full FIFO still fits.
    always_comb begin
        empty   = (wptr_q == rptr_q);
        full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        do_pop  = evt_pop && !empty;
        do_push = evt_made && (!full || do_pop);
        drop    = evt_made && full && !do_pop;
        wptr_d  = wptr_q + PW'(do_push);
        rptr_d  = rptr_q + PW'(do_pop);
        ovf_d   = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            skip_q  <= '0;
            tmo_q   <= '0;
            mod_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            tmo_q   <= tmo_d;
            mod_q   <= mod_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= evt_new;
        end
    end

    assign evt_valid  = !empty;
    assign evt_data   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign shift_held = mod_q[0] | mod_q[1];
    assign ctrl_held  = mod_q[2] | mod_q[3];
    assign alt_held   = mod_q[4] | mod_q[5];
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Bench for ps2_scancode_decoder: directed scenarios plus random byte streams
// compared cycle by cycle against a prefix-queue reference model.
module tb_ps2_scancode_decoder;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       code_valid = 1'b0;
    logic [7:0] code_in = '0;
    logic       evt_pop = 1'b0;
    logic       ovf_clr = 1'b0;
    logic       evt_valid;
    logic [9:0] evt_data;
    logic       shift_held, ctrl_held, alt_held, overflow;

    int total = 0;
    int bad   = 0;

    logic [7:0] pend[$];
    logic [9:0] fifoModel[$];
    bit         held[512];
    bit         ovfModel;
    int         idleCycles;

    ps2_scancode_decoder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .code_valid (code_valid),
        .code_in    (code_in),
        .evt_valid  (evt_valid),
        .evt_data   (evt_data),
        .evt_pop    (evt_pop),
        .shift_held (shift_held),
        .ctrl_held  (ctrl_held),
        .alt_held   (alt_held),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic bit isCtrl(input logic [7:0] b);
        return b inside {8'h00, 8'hFF, 8'hAA, 8'hFA, 8'hEE, 8'hFC};
    endfunction

    function automatic bit isPfx(input logic [7:0] b);
        return b inside {8'hE0, 8'hF0, 8'hE1};
    endfunction

    // Prefix bytes wait in a queue until a terminating byte decides the event.
    task automatic modelByte(input logic [7:0] b, output bit made, output logic [9:0] ev);
        bit junk;
        made = 1'b0;
        ev   = '0;
        junk = isPfx(b) || isCtrl(b);
        if (pend.size() > 0 && idleCycles >= TIMEOUT) pend.delete();
        if (pend.size() == 0) begin
            if (isPfx(b)) pend.push_back(b);
            else if (!isCtrl(b)) begin made = 1'b1; ev = {2'b00, b}; end
        end else if (pend[0] == 8'hE1) begin
            pend.push_back(b);
            if (pend.size() == 8) pend.delete();
        end else if (pend.size() == 1 && pend[0] == 8'hE0) begin
            if (b == 8'hF0) pend.push_back(b);
            else begin
                if (!(b == 8'h12 || b == 8'h59 || junk)) begin made = 1'b1; ev = {2'b01, b}; end
                pend.delete();
            end
        end else if (pend.size() == 1) begin
            if (!junk) begin made = 1'b1; ev = {2'b10, b}; end
            pend.delete();
        end else begin
            if (!(b == 8'h12 || b == 8'h59 || junk)) begin made = 1'b1; ev = {2'b11, b}; end
            pend.delete();
        end
    endtask

    task automatic checkModel();
        checkOutput("evt_valid", 32'(evt_valid), 32'(fifoModel.size() > 0));
        if (fifoModel.size() > 0) checkOutput("evt_data", 32'(evt_data), 32'(fifoModel[0]));
        checkOutput("shift_held", 32'(shift_held), 32'(held['h012] | held['h059]));
        checkOutput("ctrl_held", 32'(ctrl_held), 32'(held['h014] | held['h114]));
        checkOutput("alt_held", 32'(alt_held), 32'(held['h011] | held['h111]));
        checkOutput("overflow", 32'(overflow), 32'(ovfModel));
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic pop, input logic clr);
        bit         made, fullBefore, popping, dropped;
        logic [9:0] ev;
        code_valid = v;
        code_in    = b;
        evt_pop    = pop;
        ovf_clr    = clr;
        @(posedge clk);
        #1;
        made = 1'b0;
        ev   = '0;
        if (v) begin
            modelByte(b, made, ev);
            idleCycles = 0;
        end else begin
            idleCycles++;
        end
        fullBefore = (fifoModel.size() == DEPTH);
        popping    = pop && (fifoModel.size() > 0);
        dropped    = made && fullBefore && !popping;
        if (popping) void'(fifoModel.pop_front());
        if (made) begin
            held[ev[8:0]] = !ev[9];
            if (!dropped) fifoModel.push_back(ev);
        end
        if (dropped) ovfModel = 1'b1;
        else if (clr) ovfModel = 1'b0;
        code_valid = 1'b0;
        evt_pop    = 1'b0;
        ovf_clr    = 1'b0;
        checkModel();
    endtask

    task automatic doReset();
        rst_n      = 1'b0;
        code_valid = 1'b0;
        evt_pop    = 1'b0;
        ovf_clr    = 1'b0;
        #1;
        checkOutput("rst_evt_valid", 32'(evt_valid), 32'd0);
        checkOutput("rst_evt_data", 32'(evt_data), 32'd0);
        checkOutput("rst_mods", 32'({shift_held, ctrl_held, alt_held}), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend.delete();
        fifoModel.delete();
        for (int i = 0; i < 512; i++) held[i] = 1'b0;
        ovfModel   = 1'b0;
        idleCycles = 0;
    endtask

    task automatic sendByte(input logic [7:0] b);
        applyStimulus(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic popHead(input string tag, input logic [9:0] expected);
        checkOutput({tag, "_valid"}, 32'(evt_valid), 32'd1);
        checkOutput(tag, 32'(evt_data), 32'(expected));
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic sendList(input logic [7:0] bytes[$]);
        foreach (bytes[i]) sendByte(bytes[i]);
    endtask

    initial begin
        logic [7:0] seq[$];
        logic [7:0] pool[9];
        logic [7:0] k;
        bit         longGap;
        int         gap;

        doReset();

        sendList('{8'h1C, 8'hF0, 8'h1C});
        popHead("t1_make", 10'h01C);
        popHead("t1_break", 10'h21C);
        checkOutput("t1_mods", 32'({shift_held, ctrl_held, alt_held}), 32'd0);

        sendList('{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hE0, 8'h12, 8'hE0, 8'h7C});
        popHead("t2_ext_make", 10'h175);
        popHead("t2_ext_break", 10'h375);
        popHead("t2_prtsc", 10'h17C);
        checkOutput("t2_empty", 32'(evt_valid), 32'd0);

        sendList('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C});
        popHead("t3_after_pause", 10'h01C);
        checkOutput("t3_empty", 32'(evt_valid), 32'd0);
        checkOutput("t3_ctrl", 32'(ctrl_held), 32'd0);

        sendList('{8'h12, 8'hE0, 8'h14});
        checkOutput("t4_shift_on", 32'(shift_held), 32'd1);
        checkOutput("t4_ctrl_on", 32'(ctrl_held), 32'd1);
        sendList('{8'hF0, 8'h12});
        checkOutput("t4_shift_off", 32'(shift_held), 32'd0);
        sendList('{8'hE0, 8'hF0, 8'h14});
        checkOutput("t4_ctrl_off", 32'(ctrl_held), 32'd0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 9; i++) sendByte(8'(8'h20 + i));
        checkOutput("t5_overflow", 32'(overflow), 32'd1);
        for (int i = 0; i < 8; i++) popHead("t5_order", 10'(10'h020 + i));
        checkOutput("t5_drained", 32'(evt_valid), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("t5_ovf_clr", 32'(overflow), 32'd0);

        sendByte(8'hE0);
        idle(TIMEOUT);
        sendByte(8'h1C);
        popHead("t6_timeout", 10'h01C);
        sendByte(8'hF0);
        doReset();
        sendByte(8'h1C);
        popHead("t6_reset", 10'h01C);

        pool = '{8'h12, 8'h59, 8'h14, 8'h11, 8'h1C, 8'h75, 8'h7C, 8'h20, 8'h00};
        for (int n = 0; n < 400; n++) begin
            k = pool[$urandom_range(0, 8)];
            if (k == 8'h00) k = 8'($urandom);
            seq.delete();
            longGap = 1'b0;
            case ($urandom_range(0, 9))
                0, 1: seq.push_back(k);
                2, 9: begin seq.push_back(8'hF0); seq.push_back(k); end
                3: begin seq.push_back(8'hE0); seq.push_back(k); end
                4: begin seq.push_back(8'hE0); seq.push_back(8'hF0); seq.push_back(k); end
                5: seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
                6: seq.push_back(8'($urandom));
                7: seq.push_back(($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA);
                default: begin
                    seq.push_back(($urandom_range(0, 1) == 0) ? 8'hE0 : 8'hF0);
                    longGap = 1'b1;
                end
            endcase
            foreach (seq[i]) begin
                applyStimulus(1'b1, seq[i], $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
                gap = $urandom_range(0, 2);
                for (int g = 0; g < gap; g++)
                    applyStimulus(1'b0, 8'h00, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0);
            end
            if (longGap)
                for (int g = 0; g < TIMEOUT + 3; g++)
                    applyStimulus(1'b0, 8'h00, $urandom_range(0, 3) == 0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
